pc_fetch_unit: RTL

PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

---
 rtl/pc_fetch_unit.sv | 126 ++++++++++++
 1 files changed

// File: rtl/pc_fetch_unit.sv
// Instruction fetch PC sequencer: jump/branch redirect, hold, and one-cycle flush.
// Optional dynamic branch prediction compiled in with `define PC_FETCH_PREDICT_EN.
module pc_fetch_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        hold,
  input  logic        id_branch,
  input  logic        id_taken,
  input  logic [6:0]  id_target,
  input  logic        id_jump,
  input  logic [6:0]  id_jump_target,
  input  logic [31:0] instr,
  output logic [6:0]  pc,
  output logic [6:0]  PC4,
  output logic [31:0] I,
  output logic        flush
);

  localparam int unsigned AW = 7;

  // Targets are forced word-aligned so pc[1:0] stays 00.
  localparam logic [AW-1:0] ALIGN_MASK = ~AW'(3);

  logic [AW-1:0] pc_q, pc_d;
  logic [AW-1:0] pc4_c;
  logic          mispredict_c;
  logic [AW-1:0] redirect_tgt_c;
  logic          pred_taken_c;
  logic [AW-1:0] pred_tgt_c;

  assign pc4_c = pc_q + AW'(4);
  assign pc    = pc_q;
  assign PC4   = pc4_c;
  assign I     = instr;

`ifdef PC_FETCH_PREDICT_EN
  localparam int unsigned NE  = 8;
  localparam int unsigned IXW = 3;

  logic [1:0]     cnt_q [NE];
  logic [1:0]     cnt_d [NE];
  logic           spred_q, spred_d;
  logic [AW-1:0]  spc4_q, spc4_d;
  logic [IXW-1:0] sidx_q, sidx_d;
  logic [IXW-1:0] fetch_idx_c;
  logic           is_cbr_c;

  // beq (000100) and bne (000101) share the upper five opcode bits.
  assign fetch_idx_c    = pc_q[4:2];
  assign is_cbr_c       = (instr[31:27] == 5'b00010);
  assign pred_taken_c   = is_cbr_c & cnt_q[fetch_idx_c][1];
  assign pred_tgt_c     = pc4_c + {instr[4:0], 2'b00};
  assign mispredict_c   = id_branch & (id_taken != spred_q);
  assign redirect_tgt_c = id_taken ? id_target : spc4_q;
`else
  assign pred_taken_c   = 1'b0;
  assign pred_tgt_c     = pc4_c;
  assign mispredict_c   = id_branch & id_taken;
  assign redirect_tgt_c = id_target;
`endif

  // Redirect priority: jump > mispredict > hold > prediction > sequential.
  always_comb begin
    pc_d  = pc4_c;
    flush = 1'b0;
    if (!reset) begin
      if (id_jump) begin
        flush = 1'b1;
        pc_d  = id_jump_target & ALIGN_MASK;
      end else if (mispredict_c) begin
        flush = 1'b1;
        pc_d  = redirect_tgt_c & ALIGN_MASK;
      end else if (hold) begin
        pc_d = pc_q;
      end else if (pred_taken_c) begin
        pc_d = pred_tgt_c;
      end
    end
  end

`ifdef PC_FETCH_PREDICT_EN
  // Shadow of the fetched instruction's prediction, and counter training.
  always_comb begin
    spred_d = spred_q;
    spc4_d  = spc4_q;
    sidx_d  = sidx_q;
    cnt_d   = cnt_q;
    if (flush) begin
      spred_d = 1'b0;
      spc4_d  = '0;
      sidx_d  = '0;
    end else if (!hold) begin
      spred_d = pred_taken_c;
      spc4_d  = pc4_c;
      sidx_d  = fetch_idx_c;
    end
    if (id_branch && !id_jump) begin
      if (id_taken) begin
        if (cnt_q[sidx_q] != 2'b11) cnt_d[sidx_q] = cnt_q[sidx_q] + 2'(1);
      end else begin
        if (cnt_q[sidx_q] != 2'b00) cnt_d[sidx_q] = cnt_q[sidx_q] - 2'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      spred_q <= 1'b0;
      spc4_q  <= '0;
      sidx_q  <= '0;
      for (int i = 0; i < NE; i++) cnt_q[i] <= 2'b01;
    end else begin
      spred_q <= spred_d;
      spc4_q  <= spc4_d;
      sidx_q  <= sidx_d;
      cnt_q   <= cnt_d;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) pc_q <= '0;
    else       pc_q <= pc_d;
  end

endmodule
